// File: rtl/down_counter_4bit_timer.sv
// down_counter_4bit_timer
//
// Loadable down counter and interval timer, the count-down partner of the
// free-running 4-bit up counter. A start value is loaded, the counter then
// decrements on every enabled clock and raises a one-cycle terminal-count
// pulse when it runs out. In one-shot mode it parks in EXPIRED with count=0;
// in auto-reload mode it reloads the last loaded value and keeps running,
// giving a tick every reload_reg enabled cycles. It never wraps below zero.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   clr          in   1      synchronous abort back to IDLE with count=0
//   load         in   1      synchronous load of load_val, starts a run
//   load_val     in   WIDTH  start / reload value
//   en           in   1      count enable, only honoured in RUN
//   auto_reload  in   1      1 = periodic, 0 = one-shot
//   count        out  WIDTH  current counter value (registered)
//   tc           out  1      one-cycle terminal-count pulse (registered)
//   busy         out  1      high while in RUN
//   done         out  1      high while in EXPIRED (sticky until load/clr)

module down_counter_4bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic             tc_nxt;

  // State, counter, reload value and the terminal-count pulse are all
  // registered together so every output changes on the same edge. Reset
  // clears everything immediately, which also kills any pending tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  // Next-state and next-count decision with priority clr > load > en.
  // The terminal decision is taken in the cycle where count==1, so tc rises
  // together with the value that the count shows after the run ends
  // (0 in one-shot, reload_reg in periodic mode). auto_reload only matters
  // in that decision cycle. A count of 0 while in RUN cannot be reached
  // through a load, but if it ever happens the block expires quietly
  // instead of wrapping to all-ones.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;

    if (clr) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : EXPIRED;
    end else if (state == RUN && en) begin
      if (count > WIDTH'(1)) begin
        count_nxt = count - WIDTH'(1);
      end else if (count == WIDTH'(1)) begin
        tc_nxt = 1'b1;
        if (auto_reload) begin
          count_nxt = reload_reg;
        end else begin
          count_nxt = '0;
          state_nxt = EXPIRED;
        end
      end else begin
        count_nxt = '0;
        state_nxt = EXPIRED;
      end
    end
  end

  // Status flags are straight decodes of the registered state.
  always_comb begin
    busy = (state == RUN);
    done = (state == EXPIRED);
  end

endmodule
